// File: rtl/uart_frame_tx_if.sv
// Frame-transmitter control bundle: start/length handshake, payload stream and status/serial outputs.
interface uart_frame_tx_if #(
    parameter int DATA_BITS = 8
);
    logic                 frame_start;
    logic [DATA_BITS-1:0] frame_len;
    logic                 frame_ready;
    logic [DATA_BITS-1:0] pl_data;
    logic                 pl_valid;
    logic                 pl_ready;
    logic                 tx;
    logic                 busy;
    logic                 done;

    modport master (
        output frame_start, frame_len, pl_data, pl_valid,
        input  frame_ready, pl_ready, tx, busy, done
    );

    modport slave (
        input  frame_start, frame_len, pl_data, pl_valid,
        output frame_ready, pl_ready, tx, busy, done
    );
endinterface

// File: rtl/uart_frame_tx.sv
// UART frame transmitter: SOF, LEN, LEN payload characters, optional two's-complement checksum.
// Each character is start / DATA_BITS LSB-first / optional parity / STOP_BITS stop.
module uart_frame_tx #(
    parameter int         CLKS_PER_BIT = 1736,
    parameter int         DATA_BITS    = 8,
    parameter int         PARITY       = 0,
    parameter int         STOP_BITS    = 1,
    parameter int         CHECKSUM     = 0,
    parameter logic [7:0] SOF          = 8'h7E
) (
    input logic            CLK,
    input logic            reset,
    uart_frame_tx_if.slave bus
);
    localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY == 1);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_PL, START, DATA, PAR, STOP} stateT;
    typedef enum logic [2:0] {K_SOF, K_LEN, K_PL, K_CHK, K_END} kindT;

    stateT                state;
    kindT                 nextKind;
    logic [CW-1:0]        bitCnt;
    logic [3:0]           bitIdx;
    logic [DATA_BITS-1:0] lenReg, plLeft, sum, shiftReg;
    logic                 parBit;
    logic                 txReg, frameReadyReg, plReadyReg, busyReg, doneReg;

    logic [DATA_BITS-1:0] loadChar;
    kindT                 loadAfter, afterPl;
    logic                 bitEnd;

    // Character produced by LOAD and the kind that follows it in the frame.
    always_comb begin
        loadChar  = SOF[DATA_BITS-1:0];
        loadAfter = K_LEN;
        afterPl   = (CHECKSUM != 0) ? K_CHK : K_END;
        case (nextKind)
            K_LEN: begin
                loadChar  = lenReg;
                loadAfter = (lenReg != '0) ? K_PL : afterPl;
            end
            K_CHK: begin
                loadChar  = '0 - sum;
                loadAfter = K_END;
            end
            default: ;
        endcase
    end

    assign bitEnd = (bitCnt == BIT_LAST);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            nextKind      <= K_SOF;
            bitCnt        <= '0;
            bitIdx        <= '0;
            lenReg        <= '0;
            plLeft        <= '0;
            sum           <= '0;
            shiftReg      <= '0;
            parBit        <= 1'b0;
            txReg         <= 1'b1;
            frameReadyReg <= 1'b1;
            plReadyReg    <= 1'b0;
            busyReg       <= 1'b0;
            doneReg       <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                IDLE: if (bus.frame_start) begin
                    lenReg        <= bus.frame_len;
                    sum           <= '0;
                    nextKind      <= K_SOF;
                    frameReadyReg <= 1'b0;
                    busyReg       <= 1'b1;
                    state         <= LOAD;
                end
                LOAD: begin
                    shiftReg <= loadChar;
                    parBit   <= (^loadChar) ^ ODD;
                    nextKind <= loadAfter;
                    if (nextKind == K_LEN) begin
                        sum    <= sum + lenReg;
                        plLeft <= lenReg;
                    end
                    bitCnt <= '0;
                    txReg  <= 1'b0;
                    state  <= START;
                end
                WAIT_PL: if (bus.pl_valid) begin
                    shiftReg   <= bus.pl_data;
                    parBit     <= (^bus.pl_data) ^ ODD;
                    sum        <= sum + bus.pl_data;
                    plLeft     <= plLeft - 1'b1;
                    nextKind   <= (plLeft == DATA_BITS'(1)) ? afterPl : K_PL;
                    plReadyReg <= 1'b0;
                    bitCnt     <= '0;
                    txReg      <= 1'b0;
                    state      <= START;
                end
                START: if (bitEnd) begin
                    bitCnt <= '0;
                    bitIdx <= '0;
                    txReg  <= shiftReg[0];
                    state  <= DATA;
                end else bitCnt <= bitCnt + 1'b1;
                DATA: if (bitEnd) begin
                    bitCnt <= '0;
                    if (bitIdx == DATA_LAST) begin
                        bitIdx <= '0;
                        if (PARITY != 0) begin
                            txReg <= parBit;
                            state <= PAR;
                        end else begin
                            txReg <= 1'b1;
                            state <= STOP;
                        end
                    end else begin
                        bitIdx   <= bitIdx + 1'b1;
                        shiftReg <= shiftReg >> 1;
                        txReg    <= shiftReg[1];
                    end
                end else bitCnt <= bitCnt + 1'b1;
                PAR: if (bitEnd) begin
                    bitCnt <= '0;
                    txReg  <= 1'b1;
                    state  <= STOP;
                end else bitCnt <= bitCnt + 1'b1;
                STOP: if (bitEnd) begin
                    bitCnt <= '0;
                    if (bitIdx == STOP_LAST) begin
                        bitIdx <= '0;
                        case (nextKind)
                            K_END: begin
                                busyReg       <= 1'b0;
                                frameReadyReg <= 1'b1;
                                doneReg       <= 1'b1;
                                state         <= IDLE;
                            end
                            K_PL: begin
                                plReadyReg <= 1'b1;
                                state      <= WAIT_PL;
                            end
                            default: state <= LOAD;
                        endcase
                    end else bitIdx <= bitIdx + 1'b1;
                end else bitCnt <= bitCnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx          = txReg;
    assign bus.frame_ready = frameReadyReg;
    assign bus.pl_ready    = plReadyReg;
    assign bus.busy        = busyReg;
    assign bus.done        = doneReg;
endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: four configurations, serial-line decoder checked against a character scoreboard.
module tb_uart_frame_tx;
    localparam int CPB = 4;

    logic CLK, reset;
    logic [3:0] fs, plv;
    logic [7:0] flen [4];
    logic [7:0] pld  [4];
    wire  [3:0] txw, frw, plrw, busyw, dnw;

    int parCfg  [4] = '{0, 0, 2, 1};
    int stopCfg [4] = '{1, 1, 2, 1};
    int chkCfg  [4] = '{0, 1, 0, 1};

    int nTests = 0, nFail = 0;
    int cur = 0;
    bit monEn = 1'b1;
    logic [7:0] expQ[$];
    logic       parQ[$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 4; g++) begin : gd
        localparam int PAR = (g == 2) ? 2 : (g == 3) ? 1 : 0;
        localparam int STP = (g == 2) ? 2 : 1;
        localparam int CHK = (g == 1 || g == 3) ? 1 : 0;
        uart_frame_tx_if #(.DATA_BITS(8)) bus ();
        assign bus.frame_start = fs[g];
        assign bus.frame_len   = flen[g];
        assign bus.pl_data     = pld[g];
        assign bus.pl_valid    = plv[g];
        assign txw[g]   = bus.tx;
        assign frw[g]   = bus.frame_ready;
        assign plrw[g]  = bus.pl_ready;
        assign busyw[g] = bus.busy;
        assign dnw[g]   = bus.done;
        uart_frame_tx #(
            .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR),
            .STOP_BITS(STP), .CHECKSUM(CHK), .SOF(8'h7E)
        ) dut (
            .CLK(CLK), .reset(reset), .bus(bus.slave)
        );
    end

    // One bit time on the line; flags any level change inside the bit.
    task automatic get_bit(input int d, output logic v, output bit bad);
        bad = 1'b0;
        @(negedge CLK);
        v = txw[d];
        repeat (CPB - 1) begin
            @(negedge CLK);
            if (txw[d] !== v) bad = 1'b1;
        end
    endtask

    // Line decoder: each received character is popped against the scoreboard.
    initial begin : mon
        int d;
        bit bad, b;
        logic v, pv, parErr;
        logic [7:0] ch, e;
        forever begin
            @(negedge CLK);
            if (monEn && reset === 1'b1 && txw[cur] === 1'b0) begin
                d = cur; bad = 1'b0; parErr = 1'b0;
                repeat (CPB - 1) begin
                    @(negedge CLK);
                    if (txw[d] !== 1'b0) bad = 1'b1;
                end
                for (int i = 0; i < 8; i++) begin
                    get_bit(d, v, b);
                    bad |= b;
                    ch[i] = v;
                end
                if (parCfg[d] != 0) begin
                    get_bit(d, pv, b);
                    bad |= b;
                    parQ.push_back(pv);
                    if (pv !== ((^ch) ^ (parCfg[d] == 1))) parErr = 1'b1;
                end
                for (int s = 0; s < stopCfg[d]; s++) begin
                    get_bit(d, v, b);
                    if (b || v !== 1'b1) bad = 1'b1;
                end
                nTests++;
                if (expQ.size() == 0) begin
                    nFail++;
                    $display("FAIL char_unexpected: got %h, none expected", ch);
                end else begin
                    e = expQ.pop_front();
                    if (ch !== e || bad || parErr) begin
                        nFail++;
                        $display("FAIL char: got %h exp %h shape_err=%0d par_err=%0d", ch, e, bad, parErr);
                    end
                end
            end
        end
    end

    // Runs one frame on DUT d, pushing the expected characters and reporting timing.
    task automatic drive_frame(input int d, input int len, input logic [7:0] pay[8],
                               input int stall, input bit hold,
                               output int doneCyc, output int hsCnt, output int rdyCyc,
                               output bit loadOk, output bit frAtDone);
        int idx = 0, stallLeft = stall, cyc = 0, sum;
        bit hsPend = 1'b0;
        cur = d;
        parQ.delete();
        expQ.push_back(8'h7E);
        expQ.push_back(8'(len));
        sum = len;
        for (int i = 0; i < len; i++) begin
            expQ.push_back(pay[i]);
            sum += pay[i];
        end
        if (chkCfg[d] != 0) expQ.push_back(8'(256 - (sum % 256)));
        fs[d] = 1'b1; flen[d] = 8'(len);
        doneCyc = -1; hsCnt = 0; rdyCyc = 0; loadOk = 1'b0; frAtDone = 1'b0;
        @(posedge CLK);
        #1;
        if (hold) flen[d] = 8'd5;
        else fs[d] = 1'b0;
        while (cyc < 3000 && doneCyc < 0) begin
            @(negedge CLK);
            cyc++;
            if (hsPend) begin idx++; hsPend = 1'b0; end
            pld[d] = (idx < 8) ? pay[idx] : 8'h00;
            if (plrw[d] && stallLeft > 0) begin
                plv[d] = 1'b0;
                stallLeft--;
            end else plv[d] = (idx < len);
            if (plrw[d]) rdyCyc++;
            if (plv[d] && plrw[d]) begin hsPend = 1'b1; hsCnt++; end
            if (cyc == 1) loadOk = busyw[d] && !frw[d] && !plrw[d] && txw[d];
            if (cyc == 2) loadOk = loadOk && !txw[d];
            if (dnw[d]) begin doneCyc = cyc; frAtDone = frw[d]; end
        end
        plv[d] = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge CLK);
        for (int k = 0; k < 2; k++) begin
            nTests += 5;
            if (txw !== 4'hF)   begin nFail++; $display("FAIL reset_tx[%0d]: got %b exp 1111", k, txw); end
            if (frw !== 4'hF)   begin nFail++; $display("FAIL reset_frame_ready[%0d]: got %b exp 1111", k, frw); end
            if (plrw !== 4'h0)  begin nFail++; $display("FAIL reset_pl_ready[%0d]: got %b exp 0000", k, plrw); end
            if (busyw !== 4'h0) begin nFail++; $display("FAIL reset_busy[%0d]: got %b exp 0000", k, busyw); end
            if (dnw !== 4'h0)   begin nFail++; $display("FAIL reset_done[%0d]: got %b exp 0000", k, dnw); end
            reset = 1'b1;
            @(negedge CLK);
        end
    endtask

    task automatic test_basic;
        logic [7:0] p[8];
        int dc, hs, rc; bit lo, fr;
        p = '{8'hA8, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        drive_frame(0, 4, p, 0, 1'b0, dc, hs, rc, lo, fr);
        nTests += 5;
        if (dc !== 247) begin nFail++; $display("FAIL basic_done_cycle: got %0d exp 247", dc); end
        if (hs !== 4)   begin nFail++; $display("FAIL basic_handshakes: got %0d exp 4", hs); end
        if (!lo)        begin nFail++; $display("FAIL basic_load_cycle: got %0d exp 1", lo); end
        if (!fr)        begin nFail++; $display("FAIL basic_ready_at_done: got %0d exp 1", fr); end
        if (expQ.size() != 0) begin nFail++; $display("FAIL basic_chars_left: got %0d exp 0", expQ.size()); end
    endtask

    task automatic test_checksum;
        logic [7:0] p[8];
        int dc, hs, rc; bit lo, fr;
        p = '{8'hA8, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        drive_frame(1, 4, p, 0, 1'b0, dc, hs, rc, lo, fr);
        nTests += 3;
        if (dc !== 288) begin nFail++; $display("FAIL chk_done_cycle: got %0d exp 288", dc); end
        if (hs !== 4)   begin nFail++; $display("FAIL chk_handshakes: got %0d exp 4", hs); end
        if (expQ.size() != 0) begin nFail++; $display("FAIL chk_chars_left: got %0d exp 0", expQ.size()); end
    endtask

    task automatic test_parity;
        logic [7:0] p[8];
        int dc, hs, rc; bit lo, fr;
        p = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        drive_frame(2, 1, p, 0, 1'b0, dc, hs, rc, lo, fr);
        nTests += 3;
        if (dc !== 148) begin nFail++; $display("FAIL even_done_cycle: got %0d exp 148", dc); end
        if (parQ.size() == 0 || parQ[0] !== 1'b0) begin nFail++; $display("FAIL even_sof_parity: got %0d exp 0", (parQ.size() != 0) ? parQ[0] : 1'bx); end
        if (expQ.size() != 0) begin nFail++; $display("FAIL even_chars_left: got %0d exp 0", expQ.size()); end
        p = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        drive_frame(3, 2, p, 0, 1'b0, dc, hs, rc, lo, fr);
        nTests += 3;
        if (dc !== 226) begin nFail++; $display("FAIL odd_done_cycle: got %0d exp 226", dc); end
        if (parQ.size() == 0 || parQ[0] !== 1'b1) begin nFail++; $display("FAIL odd_sof_parity: got %0d exp 1", (parQ.size() != 0) ? parQ[0] : 1'bx); end
        if (expQ.size() != 0) begin nFail++; $display("FAIL odd_chars_left: got %0d exp 0", expQ.size()); end
    endtask

    task automatic test_stall_empty;
        logic [7:0] p[8];
        int dc, hs, rc; bit lo, fr;
        p = '{8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        drive_frame(0, 2, p, 10, 1'b0, dc, hs, rc, lo, fr);
        nTests += 3;
        if (dc !== 175) begin nFail++; $display("FAIL stall_done_cycle: got %0d exp 175", dc); end
        if (rc !== 12)  begin nFail++; $display("FAIL stall_ready_cycles: got %0d exp 12", rc); end
        if (expQ.size() != 0) begin nFail++; $display("FAIL stall_chars_left: got %0d exp 0", expQ.size()); end
        drive_frame(0, 0, p, 0, 1'b0, dc, hs, rc, lo, fr);
        nTests += 3;
        if (dc !== 83) begin nFail++; $display("FAIL empty_done_cycle: got %0d exp 83", dc); end
        if (hs !== 0)  begin nFail++; $display("FAIL empty_handshakes: got %0d exp 0", hs); end
        if (expQ.size() != 0) begin nFail++; $display("FAIL empty_chars_left: got %0d exp 0", expQ.size()); end
        drive_frame(1, 0, p, 0, 1'b0, dc, hs, rc, lo, fr);
        nTests += 2;
        if (dc !== 124) begin nFail++; $display("FAIL empty_chk_done_cycle: got %0d exp 124", dc); end
        if (expQ.size() != 0) begin nFail++; $display("FAIL empty_chk_chars_left: got %0d exp 0", expQ.size()); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] p[8];
        int dc, hs, rc; bit lo, fr;
        p = '{8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        drive_frame(0, 1, p, 0, 1'b1, dc, hs, rc, lo, fr);
        nTests += 3;
        if (dc !== 124) begin nFail++; $display("FAIL b2b_first_done: got %0d exp 124", dc); end
        if (!fr)        begin nFail++; $display("FAIL b2b_ready_at_done: got %0d exp 1", fr); end
        if (hs !== 1)   begin nFail++; $display("FAIL b2b_first_handshakes: got %0d exp 1", hs); end
        p = '{8'h44, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        drive_frame(0, 2, p, 0, 1'b0, dc, hs, rc, lo, fr);
        nTests += 3;
        if (!lo)        begin nFail++; $display("FAIL b2b_load_after_done: got %0d exp 1", lo); end
        if (dc !== 165) begin nFail++; $display("FAIL b2b_second_done: got %0d exp 165", dc); end
        if (expQ.size() != 0) begin nFail++; $display("FAIL b2b_chars_left: got %0d exp 0", expQ.size()); end
    endtask

    task automatic test_reset_mid;
        bit seen = 1'b0;
        monEn = 1'b0; cur = 0;
        fs[0] = 1'b1; flen[0] = 8'd4; pld[0] = 8'hA8; plv[0] = 1'b1;
        @(posedge CLK);
        #1 fs[0] = 1'b0;
        // cycle 52 sits in bit 1 of LEN (0x04), a low bit
        repeat (52) @(negedge CLK);
        nTests++;
        if (txw[0] !== 1'b0) begin nFail++; $display("FAIL rst_pre_tx: got %b exp 0", txw[0]); end
        reset = 1'b0;
        #1;
        nTests += 3;
        if (txw[0] !== 1'b1)  begin nFail++; $display("FAIL rst_async_tx: got %b exp 1", txw[0]); end
        if (busyw[0] !== 1'b0) begin nFail++; $display("FAIL rst_async_busy: got %b exp 0", busyw[0]); end
        if (dnw[0] !== 1'b0)  begin nFail++; $display("FAIL rst_async_done: got %b exp 0", dnw[0]); end
        repeat (3) @(negedge CLK);
        reset = 1'b1; plv[0] = 1'b0;
        repeat (6) begin
            @(negedge CLK);
            seen |= (dnw[0] !== 1'b0) || (busyw[0] !== 1'b0) || (txw[0] !== 1'b1);
        end
        nTests += 2;
        if (seen) begin nFail++; $display("FAIL rst_post_idle: got activity exp idle"); end
        if (frw[0] !== 1'b1) begin nFail++; $display("FAIL rst_post_ready: got %b exp 1", frw[0]); end
        monEn = 1'b1;
    endtask

    initial begin
        reset = 1'b0; fs = '0; plv = '0;
        for (int i = 0; i < 4; i++) begin flen[i] = '0; pld[i] = '0; end
        test_reset();
        test_basic();
        test_checksum();
        test_parity();
        test_stall_empty();
        test_back_to_back();
        test_reset_mid();
        repeat (5) @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

Parametrised UART frame transmitter for the host/target serial link. It serialises the link's frame format, which is SOF, then LEN, then LEN payload bytes, then an optional checksum. The block is the synthesizable transmit-side counterpart of the frame parser inside ClockBaseTop. It adds configurable bit time, data width, parity, stop bits and checksum.

## Interface
Parameters:
- CLKS_PER_BIT, 1736, clock cycles per UART bit (1736 = 57600 baud @ 100 MHz); must be ≥ 2
- DATA_BITS, 8, bits per character (5..8); LEN, payload and checksum are all this width
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, 1 or 2
- CHECKSUM, 0, 1 = append checksum character after payload
- SOF, 8'h7E, start-of-frame character (low DATA_BITS used)

Ports:
- CLK  in  1  system clock; one clock domain
- reset  in  1  asynchronous, active-low reset
- frame_start  in  1  request a new frame; sampled only while frame_ready=1
- frame_len  in  DATA_BITS  payload byte count; captured on start handshake
- frame_ready  out  1  high only in IDLE
- pl_data  in  DATA_BITS  payload character
- pl_valid  in  1  pl_data valid
- pl_ready  out  1  high only in WAIT_PL; transfer when pl_valid & pl_ready
- tx  out  1  serial line, idle high
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at frame completion

## Operation
- Reset values: tx=1, frame_ready=1, pl_ready=0, busy=0, done=0; FSM=IDLE; all counters and the checksum are 0.
- FSM states: IDLE, LOAD, WAIT_PL, START, DATA, PAR, STOP.
- IDLE: when frame_start=1, capture frame_len and go to LOAD with next char = SOF.
- LOAD (1 cycle): loads the shift register with the next header or checksum character, then goes to START.
- WAIT_PL: payload character slot. On the handshake, latch pl_data and go to START. Otherwise hold with tx=1, with no limit.
- Character sequence: SOF, then LEN, then frame_len payload characters, then the checksum if CHECKSUM=1.
- frame_len=0 skips payload entirely.
- START: tx=0 for one bit time.
- DATA: LSB first, for DATA_BITS bit times.
- PAR: present only if PARITY≠0.
  - even: parity bit = XOR of data bits.
  - odd: parity bit = inverted XOR of data bits.
- STOP: tx=1 for STOP_BITS bit times.
- After STOP: go to LOAD/WAIT_PL for the next character, or to IDLE after the last one.
- Checksum: running sum of LEN and all payload characters, mod 2^DATA_BITS. The transmitted value is its two's complement, so LEN + payload + chk ≡ 0. SOF is excluded.
- The running sum is cleared at the start handshake.
- frame_start while busy: ignored.
- pl_valid outside WAIT_PL: ignored; no data is consumed.
- Asynchronous reset mid-frame: tx returns to 1 immediately. The frame is abandoned, done is not pulsed, and the FSM is in IDLE after release.

## Timing
- Start handshake at cycle 0 (IDLE, frame_start=1). LOAD at cycle 1. First start bit begins at cycle 2.
- Each bit lasts exactly CLKS_PER_BIT cycles, counted by a $clog2(CLKS_PER_BIT)-bit counter.
- Character length C = CLKS_PER_BIT × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) cycles.
- Exactly one tx=1 gap cycle (LOAD or WAIT_PL) occurs between consecutive characters when payload is already valid. Each extra cycle of pl_valid=0 in WAIT_PL adds one gap cycle.
- pl_ready is registered from the state and asserts in the first WAIT_PL cycle. The start bit begins the cycle after the handshake.
- done=1 and frame_ready=1 occur in the first IDLE cycle after the last stop bit. A new frame_start is accepted in that same cycle.
- Unstalled frame with N characters: the final stop bit ends at cycle 1 + N·C + (N−1). done is asserted at cycle 2 + N·C + (N−1).

## Test plan
- Reset: assert reset=0 mid-DATA of the second character. tx=1 within the same cycle; busy=0 and done=0 held. After release, frame_ready=1.
- Basic frame, defaults except CLKS_PER_BIT=4: frame_len=4, payload A8 00 00 00, pl_valid held high.
  - tx decodes to 7E 04 A8 00 00 00; C=40.
  - done at cycle 2+6·40+5=247; pl_ready handshakes exactly 4 times.
- Checksum: CHECKSUM=1, same frame. A 7th character 0x54 is sent (04+A8=AC, two's complement 54). done at cycle 2+7·40+6=288.
- Parity/stop: PARITY=2, STOP_BITS=2, DATA_BITS=8, SOF=7E.
  - The SOF parity bit is 0; with PARITY=1 it is 1.
  - Stop high for 2 bit times; C=12·CLKS_PER_BIT.
- Stall/empty: frame_len=2, pl_valid=0 for 10 cycles at the first WAIT_PL. tx stays high for 11 gap cycles and done is delayed by 10 cycles. frame_len=0 sends only 7E 00 (plus 00 checksum if enabled).
- Back-to-back/ignored start: frame_start pulsed while busy is ignored. frame_start held high across done starts the second frame at the done cycle; its LOAD follows on the next cycle.
